// File: rtl/core_boot_sequencer.sv
// Boot sequencer: streams instruction words, register presets, barrier mask,
// start PC and a terminating NULL packet from two image ROMs into a core.

package core_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NULL  = 3'd0,
        OP_INSTR = 3'd1,
        OP_REG   = 3'd2,
        OP_BAR   = 3'd3,
        OP_PC    = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [3:0]  reserved;
        logic [9:0]  id;
        net_op_e     net_op;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;

endpackage

module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int unsigned instr_count_p = 1024,
    parameter int unsigned reg_count_p   = 64,
    parameter logic [9:0]  core_id_p     = 10'b0000000001,
    parameter logic [9:0]  bar_addr_p    = 10'd24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_i,
    input  logic [31:0]                        bar_mask_i,
    input  logic [31:0]                        pc_start_i,
    output logic [$clog2(instr_count_p)-1:0]   instr_addr_o,
    input  logic [15:0]                        instr_data_i,
    output logic [$clog2(reg_count_p)-1:0]     reg_addr_o,
    input  logic [39:0]                        reg_data_i,
    output logic [$bits(net_packet_s)-1:0]     net_packet_flat_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int unsigned IAW = $clog2(instr_count_p);
    localparam int unsigned RAW = $clog2(reg_count_p);
    localparam logic [IAW-1:0] INSTR_LAST = IAW'(instr_count_p - 1);
    localparam logic [RAW-1:0] REG_LAST   = RAW'(reg_count_p - 1);
    localparam logic [31:0]    NULL_DATA  = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_REG,
        S_TAIL,
        S_DONE
    } state_e;

    state_e         state;
    logic [1:0]     tail_cnt;
    logic           tag_valid;
    logic           tag_phase;
    logic [IAW-1:0] tag_idx;
    logic [31:0]    mask_q;
    logic [31:0]    pc_q;
    net_packet_s    pkt_q;
    net_packet_s    rom_pkt_c;
    logic           unused_reg_bits;

    assign net_packet_flat_o = pkt_q;
    assign unused_reg_bits   = ^reg_data_i[39:38];

    function automatic net_packet_s make_pkt(net_op_e op, logic [9:0] addr, logic [31:0] data);
        net_packet_s p;
        p.reserved = 4'b0;
        p.id       = core_id_p;
        p.net_op   = op;
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    // Format ROM data returned for the read tagged one cycle earlier.
    always_comb begin
        rom_pkt_c = make_pkt(OP_INSTR, 10'(tag_idx), {16'b0, instr_data_i});
        if (tag_phase) begin
            rom_pkt_c = make_pkt(OP_REG, 10'(reg_data_i[37:32]), reg_data_i[31:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tail_cnt     <= 2'd0;
            tag_valid    <= 1'b0;
            tag_phase    <= 1'b0;
            tag_idx      <= '0;
            mask_q       <= 32'd0;
            pc_q         <= 32'd0;
            pkt_q        <= '0;
            instr_addr_o <= '0;
            reg_addr_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            if (tag_valid) begin
                pkt_q <= rom_pkt_c;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    // Output is held (zeros or NULL) until the first new packet arrives.
                    if (start_i) begin
                        state        <= S_INSTR;
                        instr_addr_o <= '0;
                        reg_addr_o   <= '0;
                        mask_q       <= bar_mask_i;
                        pc_q         <= pc_start_i;
                        tail_cnt     <= 2'd0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                    end
                end
                S_INSTR: begin
                    tag_valid <= 1'b1;
                    tag_phase <= 1'b0;
                    tag_idx   <= instr_addr_o;
                    if (instr_addr_o == INSTR_LAST) begin
                        state <= S_REG;
                    end else begin
                        instr_addr_o <= instr_addr_o + IAW'(1);
                    end
                end
                S_REG: begin
                    tag_valid <= 1'b1;
                    tag_phase <= 1'b1;
                    if (reg_addr_o == REG_LAST) begin
                        state <= S_TAIL;
                    end else begin
                        reg_addr_o <= reg_addr_o + RAW'(1);
                    end
                end
                S_TAIL: begin
                    // Step 0 lets the last REG packet drain out of the tag stage.
                    tail_cnt <= tail_cnt + 2'd1;
                    case (tail_cnt)
                        2'd1: pkt_q <= make_pkt(OP_BAR, bar_addr_p, mask_q);
                        2'd2: pkt_q <= make_pkt(OP_PC, 10'd0, pc_q);
                        2'd3: begin
                            pkt_q  <= make_pkt(OP_NULL, bar_addr_p, NULL_DATA);
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end
                        default: ;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Randomized self-checking bench for core_boot_sequencer: a small 4/4 instance
// and a default 1024/64 instance, both checked against a packet-stream model.

module tb_core_boot_sequencer;
    import core_boot_sequencer_pkg::*;

    localparam int unsigned PW = $bits(net_packet_s);
    localparam int SIC = 4;
    localparam int SRC = 4;
    localparam int DIC = 1024;
    localparam int DRC = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          start_s = 1'b0;
    logic [31:0]   mask_s = 32'd0;
    logic [31:0]   pc_s = 32'd0;
    logic [1:0]    iaddr_s;
    logic [15:0]   idata_s;
    logic [1:0]    raddr_s;
    logic [39:0]   rdata_s;
    logic [PW-1:0] pkt_s;
    logic          busy_s;
    logic          done_s;

    logic          start_d = 1'b0;
    logic [31:0]   mask_d = 32'd0;
    logic [31:0]   pc_d = 32'd0;
    logic [9:0]    iaddr_d;
    logic [15:0]   idata_d;
    logic [5:0]    raddr_d;
    logic [39:0]   rdata_d;
    logic [PW-1:0] pkt_d;
    logic          busy_d;
    logic          done_d;

    logic [15:0] irom [DIC];
    logic [39:0] rrom [DRC];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_boot_sequencer #(.instr_count_p(SIC), .reg_count_p(SRC)) dut_s (
        .clk(clk), .reset(reset), .start_i(start_s), .bar_mask_i(mask_s), .pc_start_i(pc_s),
        .instr_addr_o(iaddr_s), .instr_data_i(idata_s), .reg_addr_o(raddr_s), .reg_data_i(rdata_s),
        .net_packet_flat_o(pkt_s), .busy_o(busy_s), .done_o(done_s)
    );

    core_boot_sequencer dut_d (
        .clk(clk), .reset(reset), .start_i(start_d), .bar_mask_i(mask_d), .pc_start_i(pc_d),
        .instr_addr_o(iaddr_d), .instr_data_i(idata_d), .reg_addr_o(raddr_d), .reg_data_i(rdata_d),
        .net_packet_flat_o(pkt_d), .busy_o(busy_d), .done_o(done_d)
    );

    // Synchronous image ROMs shared by both instances.
    always @(posedge clk) begin
        idata_s <= irom[iaddr_s];
        rdata_s <= rrom[raddr_s];
        idata_d <= irom[iaddr_d];
        rdata_d <= rrom[raddr_d];
    end

    // Packet k of a boot stream of ic instructions and rc registers.
    function automatic net_packet_s model_pkt(int k, int ic, int rc, logic [31:0] m, logic [31:0] p);
        net_packet_s r;
        logic [39:0] e;
        r.reserved = 4'd0;
        r.id = 10'd1;
        if (k < ic) begin
            r.net_op = OP_INSTR;
            r.net_addr = 10'(k);
            r.net_data = {16'd0, irom[k]};
        end else if (k < ic + rc) begin
            e = rrom[k - ic];
            r.net_op = OP_REG;
            r.net_addr = {4'd0, e[37:32]};
            r.net_data = e[31:0];
        end else if (k == ic + rc) begin
            r.net_op = OP_BAR;
            r.net_addr = 10'd24;
            r.net_data = m;
        end else if (k == ic + rc + 1) begin
            r.net_op = OP_PC;
            r.net_addr = 10'd0;
            r.net_data = p;
        end else begin
            r.net_op = OP_NULL;
            r.net_addr = 10'd24;
            r.net_data = 32'hFFFF_FFFE;
        end
        return r;
    endfunction

    task automatic randomize_roms();
        for (int i = 0; i < DIC; i++) irom[i] = 16'($urandom);
        for (int i = 0; i < DRC; i++) rrom[i] = {8'($urandom), 32'($urandom)};
    endtask

    // Boots the small instance and checks every output cycle against the model.
    task automatic run_stream(input string name, input bit from_done, input int stray_start,
                              input logic [31:0] m, input logic [31:0] p);
        net_packet_s got;
        net_packet_s exp;
        logic exp_busy;
        logic exp_done;
        int total;
        total = SIC + SRC + 4 + 24;
        @(negedge clk);
        start_s = 1'b1;
        mask_s = m;
        pc_s = p;
        @(posedge clk);
        for (int n = 0; n < total; n++) begin
            @(negedge clk);
            start_s = (n + 1 == stray_start);
            mask_s = $urandom;
            pc_s = $urandom;
            got = net_packet_s'(pkt_s);
            if (n < 2) exp = from_done ? model_pkt(SIC + SRC + 2, SIC, SRC, m, p) : '0;
            else exp = model_pkt(n - 2, SIC, SRC, m, p);
            exp_busy = (n <= SIC + SRC + 3);
            exp_done = (n >= SIC + SRC + 4);
            checks += 3;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s pkt after E%0d: got %h expected %h", name, n, got, exp);
            end
            if (busy_s !== exp_busy) begin
                errors++;
                $display("FAIL %s busy after E%0d: got %b expected %b", name, n, busy_s, exp_busy);
            end
            if (done_s !== exp_done) begin
                errors++;
                $display("FAIL %s done after E%0d: got %b expected %b", name, n, done_s, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (pkt_s !== '0) begin errors++; $display("FAIL reset pkt: got %h expected 0", pkt_s); end
        if (busy_s !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy_s); end
        if (done_s !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done_s); end
        if (iaddr_s !== 2'd0) begin errors++; $display("FAIL reset iaddr: got %0d expected 0", iaddr_s); end
        if (raddr_s !== 2'd0) begin errors++; $display("FAIL reset raddr: got %0d expected 0", raddr_s); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        randomize_roms();
        irom[0] = 16'h1111;
        irom[1] = 16'h2222;
        irom[2] = 16'h3333;
        irom[3] = 16'h4444;
        rrom[0] = 40'h05_DEADBEEF;
        run_stream("basic", 1'b0, 0, 32'h2, 32'h5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] m;
        logic [31:0] p;
        m = $urandom;
        p = $urandom;
        run_stream("start_while_busy", 1'b1, 7, m, p);
        run_stream("restart_from_done", 1'b1, 0, m, p);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            randomize_roms();
            run_stream("random", 1'b1, $urandom_range(1, SIC + SRC + 3), $urandom, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_s = 1'b1;
        mask_s = $urandom;
        pc_s = $urandom;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (n == 3) reset = 1'b1;
        end
        for (int n = 4; n < 6; n++) begin
            @(negedge clk);
            reset = 1'b0;
            checks += 5;
            if (pkt_s !== '0) begin errors++; $display("FAIL midreset pkt after E%0d: got %h expected 0", n, pkt_s); end
            if (busy_s !== 1'b0) begin errors++; $display("FAIL midreset busy after E%0d: got %b expected 0", n, busy_s); end
            if (done_s !== 1'b0) begin errors++; $display("FAIL midreset done after E%0d: got %b expected 0", n, done_s); end
            if (iaddr_s !== 2'd0) begin errors++; $display("FAIL midreset iaddr after E%0d: got %0d expected 0", n, iaddr_s); end
            if (raddr_s !== 2'd0) begin errors++; $display("FAIL midreset raddr after E%0d: got %0d expected 0", n, raddr_s); end
        end
        run_stream("after_reset", 1'b0, 0, $urandom, $urandom);
    endtask

    task automatic test_default_params();
        net_packet_s got;
        net_packet_s exp;
        logic [31:0] m;
        logic [31:0] p;
        int nonnull;
        int next_instr;
        randomize_roms();
        m = $urandom;
        p = $urandom;
        nonnull = 0;
        next_instr = 0;
        @(negedge clk);
        start_d = 1'b1;
        mask_d = m;
        pc_d = p;
        @(posedge clk);
        for (int n = 0; n < DIC + DRC + 4 + 10; n++) begin
            @(negedge clk);
            start_d = 1'b0;
            mask_d = $urandom;
            pc_d = $urandom;
            got = net_packet_s'(pkt_d);
            exp = (n < 2) ? '0 : model_pkt(n - 2, DIC, DRC, m, p);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL default pkt after E%0d: got %h expected %h", n, got, exp);
            end
            if (got.net_op != OP_NULL) nonnull++;
            if (got.net_op == OP_INSTR) begin
                checks++;
                if (int'(got.net_addr) != next_instr) begin
                    errors++;
                    $display("FAIL default instr order: got addr %0d expected %0d", got.net_addr, next_instr);
                end
                next_instr++;
            end
        end
        checks += 2;
        if (nonnull != DIC + DRC + 2) begin
            errors++;
            $display("FAIL default packet count: got %0d expected %0d", nonnull, DIC + DRC + 2);
        end
        if (done_d !== 1'b1) begin
            errors++;
            $display("FAIL default done at end: got %b expected 1", done_d);
        end
    endtask

    initial begin
        randomize_roms();
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
